quad_position_counter: RTL and testbench

Front-end stage that turns the raw A/B channels of the incremental encoder into a clamped, signed-free position count.
- Stages: synchronises both channels, optionally glitch-filters them, decodes quadrature in x4 mode, and maintains the position register.
- Consumers: the BCD converter / seven-segment display path and the velocity-profile logic.
- Also provides a change strobe, direction, and a sticky illegal-transition flag.

---
 rtl/quad_position_counter_if.sv | 26 ++
 rtl/quad_position_counter.sv | 154 +++++++++++++++
 tb/tb_quad_position_counter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_position_counter_if.sv
// Bus bundle for the quadrature position counter: raw encoder channels and
// clear in, position/status out. Clock and reset stay plain module ports.
interface quad_position_counter_if #(
    parameter int COUNT_W = 13
);
    logic               i_A;
    logic               i_B;
    logic               i_clear;
    logic [COUNT_W-1:0] o_count;
    logic               o_dv;
    logic               o_dir;
    logic               o_limit;
    logic               o_err;

    // Driver side: supplies the encoder channels and clear, observes results.
    modport master (
        output i_A, i_B, i_clear,
        input  o_count, o_dv, o_dir, o_limit, o_err
    );

    // Counter side.
    modport slave (
        input  i_A, i_B, i_clear,
        output o_count, o_dv, o_dir, o_limit, o_err
    );
endinterface

// File: rtl/quad_position_counter.sv
// Quadrature (x4) position counter with clamped range.
// Raw A/B -> 2-FF synchronisers -> optional glitch filter -> decoder -> count.
// Optional feature macro: QUAD_FILTER_EN (per-channel glitch filter requiring
// FILTER_LEN consecutive stable clocks before a channel change is accepted).
module quad_position_counter #(
    parameter int COUNT_W    = 13,
    parameter int INIT_COUNT = 500,
    parameter int MIN_COUNT  = 0,
    parameter int MAX_COUNT  = 999,
    parameter int FILTER_LEN = 16
) (
    input logic                  clk,
    input logic                  n_reset,
    quad_position_counter_if.slave bus
);

    localparam logic [COUNT_W-1:0] INIT_C = COUNT_W'(INIT_COUNT);
    localparam logic [COUNT_W-1:0] MIN_C  = COUNT_W'(MIN_COUNT);
    localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_COUNT);
    localparam logic               INIT_LIMIT = (INIT_C == MIN_C) || (INIT_C == MAX_C);

    logic [1:0]         a_sync;
    logic [1:0]         b_sync;
    logic [1:0]         cur_ab;
    logic [1:0]         prev_ab;
    logic               armed;
    logic               clear_q;
    logic [COUNT_W-1:0] count_q;
    logic               dv_q;
    logic               dir_q;
    logic               limit_q;
    logic               err_q;
    logic               step_up;
    logic               step_dn;
    logic               illegal;

    function automatic logic at_limit(input logic [COUNT_W-1:0] v);
        return (v == MIN_C) || (v == MAX_C);
    endfunction

    // Two-stage synchronisers; bit 1 is the stage the rest of the logic uses.
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], bus.i_A};
            b_sync <= {b_sync[0], bus.i_B};
        end
    end

`ifdef QUAD_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] RUN_LAST = FCW'(FILTER_LEN - 1);

    logic [1:0]     syn_ab;
    logic [1:0]     filt_ab;
    logic [FCW-1:0] run_cnt [2];

    assign syn_ab = {a_sync[1], b_sync[1]};
    assign cur_ab = filt_ab;

    // Glitch filter: a channel flips only after FILTER_LEN consecutive
    // clocks of disagreement; any agreement restarts the run.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            filt_ab <= 2'b00;
            for (int i = 0; i < 2; i++) run_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (syn_ab[i] == filt_ab[i]) begin
                    run_cnt[i] <= '0;
                end else if (run_cnt[i] == RUN_LAST) begin
                    filt_ab[i] <= syn_ab[i];
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + FCW'(1);
                end
            end
        end
    end
`else
    assign cur_ab = {a_sync[1], b_sync[1]};
`endif

    // Classify the transition prev_ab -> cur_ab (up sequence 00,01,11,10).
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: ;
        endcase
    end

    // Clear, arming and the clamped position register with its status flags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= INIT_C;
            dv_q    <= 1'b0;
            dir_q   <= 1'b1;
            limit_q <= INIT_LIMIT;
            err_q   <= 1'b0;
            armed   <= 1'b0;
            prev_ab <= 2'b00;
            clear_q <= 1'b0;
        end else begin
            dv_q    <= 1'b0;
            clear_q <= bus.i_clear;
            if (bus.i_clear) begin
                count_q <= INIT_C;
                limit_q <= INIT_LIMIT;
                err_q   <= 1'b0;
                armed   <= 1'b0;
                dv_q    <= !clear_q;
            end else if (!armed) begin
                // Adopt whatever phase the encoder is in without counting.
                prev_ab <= cur_ab;
                armed   <= 1'b1;
            end else begin
                prev_ab <= cur_ab;
                if (step_up) begin
                    dir_q <= 1'b1;
                    if (count_q != MAX_C) begin
                        count_q <= count_q + COUNT_W'(1);
                        limit_q <= at_limit(count_q + COUNT_W'(1));
                        dv_q    <= 1'b1;
                    end
                end else if (step_dn) begin
                    dir_q <= 1'b0;
                    if (count_q != MIN_C) begin
                        count_q <= count_q - COUNT_W'(1);
                        limit_q <= at_limit(count_q - COUNT_W'(1));
                        dv_q    <= 1'b1;
                    end
                end else if (illegal) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_dv    = dv_q;
    assign bus.o_dir   = dir_q;
    assign bus.o_limit = limit_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_quad_position_counter.sv
// Self-checking bench for quad_position_counter. The reference model tracks
// the encoder phase as a 0..3 index into the Gray cycle and derives steps by
// modular index arithmetic; the position is a plain clamped integer.
module tb_quad_position_counter;

    localparam int COUNT_W    = 13;
    localparam int INIT_COUNT = 500;
    localparam int MIN_COUNT  = 0;
    localparam int MAX_COUNT  = 999;
    localparam int FILTER_LEN = 16;
`ifdef QUAD_FILTER_EN
    localparam int LAT = FILTER_LEN + 3;
`else
    localparam int LAT = 3;
`endif
    localparam int SP = LAT + 3;

    logic clk;
    logic n_reset;

    quad_position_counter_if #(.COUNT_W(COUNT_W)) bus ();

    quad_position_counter #(
        .COUNT_W   (COUNT_W),
        .INIT_COUNT(INIT_COUNT),
        .MIN_COUNT (MIN_COUNT),
        .MAX_COUNT (MAX_COUNT),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int dv_cnt = 0;

    // Reference model state.
    logic [1:0] m_idx;
    int         m_count;
    logic       m_dir;
    logic       m_err;

    // Count o_dv pulses, sampled away from the active edge.
    always @(negedge clk) if (bus.o_dv === 1'b1) dv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the channels from the Gray index: 0->00, 1->01, 2->11, 3->10.
    task automatic drive_idx();
        bus.i_A = m_idx[1];
        bus.i_B = m_idx[1] ^ m_idx[0];
    endtask

    // kind: 0 = forward step, 1 = reverse step, 2 = illegal double change.
    task automatic apply_step(input int kind);
        case (kind)
            0: begin
                m_idx = m_idx + 2'd1;
                m_dir = 1'b1;
                if (m_count < MAX_COUNT) m_count++;
            end
            1: begin
                m_idx = m_idx - 2'd1;
                m_dir = 1'b0;
                if (m_count > MIN_COUNT) m_count--;
            end
            default: begin
                m_idx = m_idx + 2'd2;
                m_err = 1'b1;
            end
        endcase
        drive_idx();
    endtask

    task automatic step(input int kind, input int gap);
        apply_step(kind);
        wait_clks(gap);
    endtask

    task automatic pulse_clear();
        bus.i_clear = 1'b1;
        wait_clks(1);
        bus.i_clear = 1'b0;
        m_count = INIT_COUNT;
        m_err   = 1'b0;
    endtask

    function automatic logic m_limit();
        return (m_count == MIN_COUNT) || (m_count == MAX_COUNT);
    endfunction

    initial begin
        int dv0;
        int got;
        logic [31:0] held;

        m_idx = 2'd0; m_count = INIT_COUNT; m_dir = 1'b1; m_err = 1'b0;
        n_reset = 1'b0;
        bus.i_clear = 1'b0;
        drive_idx();

        // Reset values while reset is held.
        #22;
        check("rst_count", 32'(bus.o_count), 32'(INIT_COUNT));
        check("rst_dv",    32'(bus.o_dv),    32'd0);
        check("rst_dir",   32'(bus.o_dir),   32'd1);
        check("rst_err",   32'(bus.o_err),   32'd0);
        check("rst_limit", 32'(bus.o_limit), 32'd0);

        @(negedge clk);
        n_reset = 1'b1;
        wait_clks(10);
        check("idle_count", 32'(bus.o_count), 32'(INIT_COUNT));
        check("idle_dv_pulses", 32'(dv_cnt), 32'd0);

        // First forward edge: measure input-to-o_dv latency.
        dv0 = dv_cnt;
        apply_step(0);
        got = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(negedge clk);
            if (bus.o_dv === 1'b1) begin
                got = k;
                break;
            end
        end
        check("latency", 32'(got), 32'(LAT));
        check("latency_count", 32'(bus.o_count), 32'(m_count));
        wait_clks(SP);

        // Remaining seven forward steps, then three reverse.
        for (int i = 0; i < 7; i++) step(0, 10 + LAT);
        check("fwd8_count", 32'(bus.o_count), 32'd508);
        check("fwd8_dv",    32'(dv_cnt - dv0), 32'd8);
        check("fwd8_dir",   32'(bus.o_dir), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 10 + LAT);
        check("rev3_count", 32'(bus.o_count), 32'd505);
        check("rev3_dir",   32'(bus.o_dir), 32'd0);

        // Upper clamp: clear to 500, climb to 995, then ten more forward.
        dv0 = dv_cnt;
        pulse_clear();
        wait_clks(3);
        check("clear_dv_single", 32'(dv_cnt - dv0), 32'd1);
        for (int i = 0; i < 495; i++) step(0, SP);
        check("at995", 32'(bus.o_count), 32'd995);
        dv0 = dv_cnt;
        for (int i = 0; i < 10; i++) step(0, SP);
        check("clamp_hi_count", 32'(bus.o_count), 32'(MAX_COUNT));
        check("clamp_hi_limit", 32'(bus.o_limit), 32'd1);
        check("clamp_hi_dv",    32'(dv_cnt - dv0), 32'd4);

        // Lower clamp.
        for (int i = 0; i < 995; i++) step(1, SP);
        check("at4", 32'(bus.o_count), 32'd4);
        check("mid_limit", 32'(bus.o_limit), 32'd0);
        dv0 = dv_cnt;
        for (int i = 0; i < 10; i++) step(1, SP);
        check("clamp_lo_count", 32'(bus.o_count), 32'(MIN_COUNT));
        check("clamp_lo_limit", 32'(bus.o_limit), 32'd1);
        check("clamp_lo_dv",    32'(dv_cnt - dv0), 32'd4);

        // Illegal double change: sticky error, count holds, then counts on.
        held = 32'(bus.o_count);
        step(2, SP);
        check("illegal_err",   32'(bus.o_err), 32'd1);
        check("illegal_count", 32'(bus.o_count), held);
        step(0, SP);
        step(0, SP);
        check("after_illegal_count", 32'(bus.o_count), 32'(m_count));
        check("err_sticky", 32'(bus.o_err), 32'd1);
        dv0 = dv_cnt;
        pulse_clear();
        wait_clks(SP);
        check("clear_count", 32'(bus.o_count), 32'(INIT_COUNT));
        check("clear_err",   32'(bus.o_err), 32'd0);
        check("clear_dv",    32'(dv_cnt - dv0), 32'd1);

        // Clear on the same clock the step would register: step is lost.
        held = 32'(bus.o_dir);
        dv0 = dv_cnt;
        apply_step(0);
        m_dir = held[0];
        wait_clks(LAT - 1);
        pulse_clear();
        wait_clks(SP);
        check("clr_step_count", 32'(bus.o_count), 32'(INIT_COUNT));
        check("clr_step_dv",    32'(dv_cnt - dv0), 32'd1);
        check("clr_step_dir",   32'(bus.o_dir), 32'(held));

        // Randomised walk against the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            step((r < 5) ? 0 : (r < 9) ? 1 : 2, SP + $urandom_range(0, 3));
            check("rnd_count", 32'(bus.o_count), 32'(m_count));
            check("rnd_dir",   32'(bus.o_dir),   32'(m_dir));
            check("rnd_err",   32'(bus.o_err),   32'(m_err));
            check("rnd_limit", 32'(bus.o_limit), 32'(m_limit()));
        end

`ifdef QUAD_FILTER_EN
        // Short glitch on A is swallowed by the filter.
        dv0 = dv_cnt;
        held = 32'(bus.o_count);
        bus.i_A = ~bus.i_A;
        wait_clks(5);
        drive_idx();
        wait_clks(LAT + 5);
        check("glitch_count", 32'(bus.o_count), held);
        check("glitch_dv",    32'(dv_cnt - dv0), 32'd0);
`endif

        // Asynchronous reset mid-run takes effect immediately.
        step(0, 2);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.o_count), 32'(INIT_COUNT));
        check("async_rst_err",   32'(bus.o_err),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
